// File: rtl/processor_core_pkg.sv
// Shared opcode values, FSM encoding and opcode decode helpers for the command processor.
package processor_core_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'h01;
    localparam logic [7:0] OP_JMP  = 8'h02;
    localparam logic [7:0] OP_LDI  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_DJNZ = 8'h05;
    localparam logic [7:0] OP_OUT  = 8'h06;

    typedef enum logic [2:0] {
        StIdle,
        StFSetup,
        StFClkH,
        StFClkL,
        StDecode,
        StExec,
        StDone
    } state_e;

    // Number of operand bytes following each opcode; illegal opcodes report zero.
    function automatic logic [1:0] operand_count(input logic [7:0] op);
        case (op)
            OP_JMP, OP_LDI: operand_count = 2'd2;
            OP_ADD, OP_OUT: operand_count = 2'd1;
            OP_DJNZ:        operand_count = 2'd3;
            default:        operand_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/processor_regfile.sv
// General register file: one write port, two combinational read ports, synchronous clear.
module processor_regfile #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DATA_W   = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/processor_core_seq.sv
// Byte-coded command processor: fetches instructions from the command BSRAM through a
// software-clocked port and executes a small register ISA on behalf of the Arduino.
module processor_core_seq
    import processor_core_pkg::*;
#(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic              sysclk,
    input  logic              arduino_reset,
    input  logic              arduino_execute,
    output logic              arduino_isfinished,
    output logic              arduino_error,
    output logic [DATA_W-1:0] arduino_result,
    input  logic [DATA_W-1:0] mem_cmd_dout,
    output logic [DATA_W-1:0] mem_cmd_din,
    output logic [ADDR_W-1:0] mem_cmd_ad,
    output logic              mem_cmd_ce,
    output logic              mem_cmd_wre,
    output logic              mem_cmd_oce,
    output logic              mem_cmd_clk
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ad_q, ad_d;
    logic [DATA_W-1:0] opcode_q, opcode_d, result_q, result_d;
    logic [DATA_W-1:0] opnd_q [3];
    logic [DATA_W-1:0] opnd_d [3];
    logic [1:0]        cnt_q, cnt_d, need_q, need_d;
    logic              finished_q, finished_d, error_q, error_d;
    logic              ce_q, ce_d, mclk_q, mclk_d;

    logic [7:0]        op8;
    logic              op_legal;
    logic [1:0]        op_count;
    logic [IDX_W-1:0]  sel_idx, rd_idx, rs_idx;
    logic              rf_clear, rf_we;
    logic [IDX_W-1:0]  rf_waddr, rf_raddr_a;
    logic [DATA_W-1:0] rf_wdata, rf_rdata_a, rf_rdata_b, dec_val;

    assign op8        = opcode_q[7:0];
    assign op_legal   = (opcode_q <= DATA_W'(OP_OUT));
    assign op_count   = operand_count(op8);
    assign sel_idx    = opnd_q[0][IDX_W-1:0];
    assign rd_idx     = opnd_q[0][4 +: IDX_W];
    assign rs_idx     = opnd_q[0][IDX_W-1:0];
    assign rf_raddr_a = (op8 == OP_ADD) ? rd_idx : sel_idx;
    assign dec_val    = rf_rdata_a - DATA_W'(1);

    processor_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_regfile (
        .clk     (sysclk),
        .clear   (arduino_reset | rf_clear),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rf_raddr_a),
        .rdata_a (rf_rdata_a),
        .raddr_b (rs_idx),
        .rdata_b (rf_rdata_b)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        opcode_d   = opcode_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        need_d     = need_q;
        result_d   = result_q;
        finished_d = finished_q;
        error_d    = error_q;
        rf_clear   = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = sel_idx;
        rf_wdata   = '0;

        unique case (state_q)
            StIdle: begin
                finished_d = 1'b0;
                error_d    = 1'b0;
                if (arduino_execute) begin
                    pc_d     = '0;
                    result_d = '0;
                    cnt_d    = '0;
                    rf_clear = 1'b1;
                    state_d  = StFSetup;
                end
            end
            StFSetup: state_d = StFClkH;
            StFClkH:  state_d = StFClkL;
            StFClkL: begin
                pc_d  = pc_q + ADDR_W'(1);
                cnt_d = cnt_q + 2'd1;
                // cnt_q counts bytes already fetched for this instruction; zero means opcode.
                if (cnt_q == 2'd0) begin
                    opcode_d = mem_cmd_dout;
                    state_d  = StDecode;
                end else begin
                    opnd_d[cnt_q - 2'd1] = mem_cmd_dout;
                    state_d = (cnt_q == need_q) ? StExec : StFSetup;
                end
            end
            StDecode: begin
                need_d = op_count;
                if (!op_legal) begin
                    error_d    = 1'b1;
                    finished_d = 1'b1;
                    state_d    = StDone;
                end else if (op_count != 2'd0) begin
                    state_d = StFSetup;
                end else if (op8 == OP_HALT) begin
                    finished_d = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d   = '0;
                    state_d = StFSetup;
                end
            end
            StExec: begin
                cnt_d   = '0;
                state_d = StFSetup;
                case (op8)
                    OP_JMP: pc_d = ADDR_W'({opnd_q[0], opnd_q[1]});
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = opnd_q[1];
                    end
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_waddr = rd_idx;
                        rf_wdata = rf_rdata_a + rf_rdata_b;
                    end
                    OP_DJNZ: begin
                        rf_we    = 1'b1;
                        rf_wdata = dec_val;
                        if (dec_val != '0) begin
                            pc_d = ADDR_W'({opnd_q[1], opnd_q[2]});
                        end
                    end
                    OP_OUT:  result_d = rf_rdata_a;
                    default: ;
                endcase
            end
            StDone: begin
                // Holding execute high keeps us here so a finished program never restarts.
                if (!arduino_execute) begin
                    finished_d = 1'b0;
                    error_d    = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory port strobes are registered from the next state so they change glitch-free.
    assign ce_d   = (state_d == StFSetup) || (state_d == StFClkH);
    assign mclk_d = (state_d == StFClkH);
    assign ad_d   = (state_d == StFSetup) ? pc_d : ad_q;

    always_ff @(posedge sysclk) begin
        if (arduino_reset) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ad_q       <= '0;
            opcode_q   <= '0;
            opnd_q     <= '{default: '0};
            cnt_q      <= '0;
            need_q     <= '0;
            result_q   <= '0;
            finished_q <= 1'b0;
            error_q    <= 1'b0;
            ce_q       <= 1'b0;
            mclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ad_q       <= ad_d;
            opcode_q   <= opcode_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            need_q     <= need_d;
            result_q   <= result_d;
            finished_q <= finished_d;
            error_q    <= error_d;
            ce_q       <= ce_d;
            mclk_q     <= mclk_d;
        end
    end

    assign arduino_isfinished = finished_q;
    assign arduino_error      = error_q;
    assign arduino_result     = result_q;
    assign mem_cmd_ad         = ad_q;
    assign mem_cmd_ce         = ce_q;
    assign mem_cmd_oce        = ce_q;
    assign mem_cmd_clk        = mclk_q;
    assign mem_cmd_din        = '0;
    assign mem_cmd_wre        = 1'b0;

endmodule
